ram_ctrl: RTL and testbench
===========================

RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameter data_length, default 32, SHALL set the width of data words and data ports.
REQ-002 Parameter mem_length, default 32, SHALL set the number of memory words addressed; AW = $clog2(mem_length), LW = AW+1.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 cmd_valid / cmd_ready  input / output  1 / 1  SHALL form the command handshake; a command is accepted on a cycle where both are 1.
REQ-006 cmd_read  input  1  SHALL select the burst type: 1 = read burst, 0 = write burst.
REQ-007 cmd_addr / cmd_len  input  AW / LW  SHALL give the burst start address and the word count.
REQ-008 wr_valid / wr_ready / wr_data  in / out / in  1 / 1 / data_length  SHALL form the write-data stream.
REQ-009 rd_valid / rd_ready / rd_data  out / in / out  1 / 1 / data_length  SHALL form the read-data stream.
REQ-010 busy / done  output / output  1 / 1  SHALL indicate a burst in progress and a one-cycle burst-complete pulse.
REQ-011 mem_we  output  1  SHALL drive the memory mode: 0 = write, 1 = read.
REQ-012 mem_addr / mem_wdata  output / output  AW / data_length  SHALL drive the memory address and write data.
REQ-013 mem_rdata  input  data_length  SHALL carry registered memory read data, valid the cycle after the address is presented with mem_we=1.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, WRITE, RD_ADDR, RD_CAP, RD_OUT, DONE.
REQ-015 In IDLE, cmd_ready SHALL be 1. On acceptance, the block SHALL load the address counter from cmd_addr and the remaining count from cmd_len.
REQ-016 Next state after IDLE SHALL be RD_ADDR when cmd_read=1, WRITE when cmd_read=0, and DONE when cmd_len=0 (no memory access).
REQ-017 In WRITE, wr_ready SHALL be 1, and mem_addr/mem_wdata SHALL equal the address counter and wr_data.
REQ-018 In WRITE, mem_we SHALL be 0 combinationally only in cycles where wr_valid=1; otherwise mem_we SHALL be 1.
REQ-019 Each WRITE handshake SHALL increment the address and decrement the count; the handshake that brings the count to 0 SHALL move the FSM to DONE.
REQ-020 In RD_ADDR, mem_we SHALL be 1 and mem_addr SHALL be the address counter; the next state SHALL be RD_CAP.
REQ-021 In RD_CAP, the block SHALL register mem_rdata into rd_data and move to RD_OUT.
REQ-022 In RD_OUT, rd_valid SHALL be 1 and rd_data SHALL be held stable until rd_ready=1.
REQ-023 On the RD_OUT handshake, the block SHALL increment the address and decrement the count, then go to RD_ADDR if the count is nonzero, else DONE.
REQ-024 Read latency SHALL be 2 cycles from RD_ADDR to the first rd_valid; read throughput SHALL be at most 1 word per 3 cycles.
REQ-025 The address counter SHALL wrap from mem_length-1 to 0, including for non-power-of-2 mem_length.
REQ-026 cmd_len values greater than mem_length SHALL be honoured as given, with addresses wrapping.
REQ-027 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 mem_we SHALL be 1 in every state other than WRITE, so the memory is never written outside a write handshake.
REQ-030 wr_ready SHALL be 0 outside WRITE, rd_valid SHALL be 0 outside RD_OUT, and cmd_ready SHALL be 0 outside IDLE.
REQ-031 cmd_valid asserted while busy SHALL be ignored and SHALL not be lost; the command is accepted once IDLE is re-entered.

Reset
REQ-032 When rst_n=0, the block SHALL asynchronously force: state IDLE, mem_we=1, mem_addr=0, mem_wdata=0, rd_data=0, rd_valid=0, wr_ready=0, done=0, busy=0, counters 0.
REQ-033 cmd_ready SHALL be 0 while rst_n=0 and SHALL become 1 in the first cycle after deassertion.
REQ-034 Reset asserted mid-burst SHALL abort the burst with no further memory write and no done pulse.

Verification
REQ-035 Write burst: cmd_addr=4, len=3, wr_data 0xA,0xB,0xC back-to-back -> mem_we=0 in 3 consecutive cycles at addresses 4,5,6; done pulses once; memory words 4..6 = A,B,C.
REQ-036 Read burst: cmd_addr=5, len=2, rd_ready=1 -> rd_valid 2 cycles after RD_ADDR with rd_data 0xB, then 0xC; mem_we stays 1 throughout.
REQ-037 Backpressure: during a read, rd_ready=0 for 5 cycles -> rd_valid stays 1 and rd_data is unchanged; no new RD_ADDR cycle is issued.
REQ-038 Wrap and write stall: cmd_addr=30, len=4, write with wr_valid gaps -> writes occur at 30,31,0,1, only in wr_valid cycles.
REQ-039 len=0 command -> no mem_we=0 cycle and no rd_valid; done pulses 1 cycle after acceptance; cmd_ready returns to 1.
REQ-040 rst_n pulled low after 2 of 4 write beats -> mem_we=1 immediately, outputs at reset values, busy=0, no done; a new command is accepted after release.

Source files
------------

// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: command, write-data, read-data, status and memory-port signals of ram_ctrl.
//   Command   : cmd_valid/cmd_ready handshake, cmd_read (1 = read burst), cmd_addr, cmd_len
//   Write data: wr_valid/wr_ready/wr_data stream into the controller
//   Read data : rd_valid/rd_ready/rd_data stream out of the controller
//   Status    : busy (burst in progress), done (one-cycle completion pulse)
//   Memory    : mem_we (0 = write, 1 = read), mem_addr, mem_wdata, mem_rdata (registered read)
// slave is the controller side; master is the requester side, which also models the memory.
interface ram_ctrl_if #(
  parameter int unsigned data_length = 32,
  parameter int unsigned mem_length  = 32
);
  localparam int unsigned AW = $clog2(mem_length);
  localparam int unsigned LW = AW + 1;

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_read;
  logic [AW-1:0]          cmd_addr;
  logic [LW-1:0]          cmd_len;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [data_length-1:0] wr_data;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [data_length-1:0] rd_data;
  logic                   busy;
  logic                   done;
  logic                   mem_we;
  logic [AW-1:0]          mem_addr;
  logic [data_length-1:0] mem_wdata;
  logic [data_length-1:0] mem_rdata;

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, mem_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, mem_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ram_ctrl.sv
// ram_ctrl: burst controller between a command/stream interface and a single-port RAM with
// registered read data.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ram_ctrl_if.slave (command, write stream, read stream, status, memory port)
// A write burst writes one word per wr_valid cycle; a read burst fetches one word per three
// cycles (address, capture, output). The address counter wraps at mem_length, and lengths above
// mem_length simply keep wrapping. A zero-length command goes straight to the done pulse.
module ram_ctrl #(
  parameter int unsigned data_length = 32,
  parameter int unsigned mem_length  = 32
) (
  input logic       clk,
  input logic       rst_n,
  ram_ctrl_if.slave bus
);
  localparam int unsigned AW = $clog2(mem_length);
  localparam int unsigned LW = AW + 1;
  localparam logic [AW-1:0] AddrLast = AW'(mem_length - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRdAddr,
    StRdCap,
    StRdOut,
    StDone
  } state_e;

  state_e                 state_q;
  logic [AW-1:0]          addr_q;
  logic [LW-1:0]          cnt_q;
  logic [data_length-1:0] rd_data_q;

  // Explicit wrap so non-power-of-2 depths never address past the last word.
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AddrLast) ? '0 : a + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            addr_q <= bus.cmd_addr;
            cnt_q  <= bus.cmd_len;
            if (bus.cmd_len == '0) begin
              state_q <= StDone;
            end else if (bus.cmd_read) begin
              state_q <= StRdAddr;
            end else begin
              state_q <= StWrite;
            end
          end
        end
        StWrite: begin
          if (bus.wr_valid) begin
            addr_q <= addr_inc(addr_q);
            cnt_q  <= cnt_q - LW'(1);
            if (cnt_q == LW'(1)) begin
              state_q <= StDone;
            end
          end
        end
        StRdAddr: state_q <= StRdCap;
        StRdCap: begin
          // Memory output is valid one cycle after the address was presented.
          rd_data_q <= bus.mem_rdata;
          state_q   <= StRdOut;
        end
        StRdOut: begin
          if (bus.rd_ready) begin
            addr_q  <= addr_inc(addr_q);
            cnt_q   <= cnt_q - LW'(1);
            state_q <= (cnt_q == LW'(1)) ? StDone : StRdAddr;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // cmd_ready is gated by rst_n so it stays low while reset is held.
  assign bus.cmd_ready = rst_n && (state_q == StIdle);
  assign bus.wr_ready  = (state_q == StWrite);
  // The memory is written only in cycles that complete a write handshake.
  assign bus.mem_we    = !((state_q == StWrite) && bus.wr_valid);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = (state_q == StWrite) ? bus.wr_data : '0;
  assign bus.rd_valid  = (state_q == StRdOut);
  assign bus.rd_data   = rd_data_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);

endmodule

// File: tb/tb_ram_ctrl.sv
module tb_ram_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned ML = 32;
  localparam int unsigned AW = $clog2(ML);
  localparam int unsigned LW = AW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_ctrl_if #(.data_length(DW), .mem_length(ML)) bus ();
  ram_ctrl #(.data_length(DW), .mem_length(ML)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Memory model: synchronous write when mem_we=0, registered read data.
  logic [DW-1:0] mem [ML];
  bit mem_clr_done;
  always @(posedge clk) begin
    if (!mem_clr_done) begin
      for (int i = 0; i < ML; i++) mem[i] <= '0;
      mem_clr_done <= 1'b1;
    end else if (!bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int bad_we = 0;
  logic [AW+DW-1:0] exp_wr[$];
  logic [AW+DW-1:0] obs_wr[$];
  logic [DW-1:0]    exp_rd[$];
  logic [DW-1:0]    obs_rd[$];
  int               obs_rd_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe DUT activity at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!bus.mem_we) begin
      obs_wr.push_back({bus.mem_addr, bus.mem_wdata});
      if (!bus.wr_valid) bad_we++;
    end
    if (bus.rd_valid && bus.rd_ready) begin
      obs_rd.push_back(bus.rd_data);
      obs_rd_cyc.push_back(cyc);
    end
    if (bus.done) done_cnt++;
  end

  task automatic issue_cmd(input logic rd, input logic [AW-1:0] a, input logic [LW-1:0] n,
                           output bit ok);
    bus.cmd_valid = 1'b1;
    bus.cmd_read  = rd;
    bus.cmd_addr  = a;
    bus.cmd_len   = n;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input int gap, output bit ok);
    bus.wr_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.wr_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.done) ok = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.mem_we, bus.wr_ready, bus.rd_valid, bus.done} !== 6'b001000)
    begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 001000", {bus.cmd_ready, bus.busy, bus.mem_we,
               bus.wr_ready, bus.rd_valid, bus.done});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.rd_data} !== '0) begin
      failures++;
      $display("FAIL reset_data: got addr=%0d wdata=%h rdata=%h want 0", bus.mem_addr,
               bus.mem_wdata, bus.rd_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b want 1", bus.cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_burst;
    int d0, b0;
    bit ok, all_ok;
    logic [AW+DW-1:0] e, o;
    logic [DW-1:0] data [3];
    data[0] = 32'hA; data[1] = 32'hB; data[2] = 32'hC;
    d0 = done_cnt; b0 = bad_we; all_ok = 1'b1;
    for (int i = 0; i < 3; i++) exp_wr.push_back({AW'(4 + i), data[i]});
    issue_cmd(1'b0, AW'(4), LW'(3), ok);
    all_ok &= ok;
    for (int i = 0; i < 3; i++) begin send_beat(data[i], 0, ok); all_ok &= ok; end
    wait_done(ok);
    all_ok &= ok;
    checks++;
    if (!all_ok) begin failures++; $display("FAIL wr_handshakes: got timeout want completion"); end
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++; $display("FAIL wr_done_pulses: got %0d want 1", done_cnt - d0);
    end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = '0;
      if (obs_wr.size() > 0) o = obs_wr.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL wr_sb: got addr=%0d data=%h want addr=%0d data=%h", o[DW+:AW], o[DW-1:0],
                 e[DW+:AW], e[DW-1:0]);
      end
    end
    checks++;
    if (obs_wr.size() != 0) begin
      failures++; $display("FAIL wr_extra: got %0d extra writes want 0", obs_wr.size());
    end
    obs_wr.delete();
    checks++;
    if (bad_we != b0) begin failures++; $display("FAIL wr_we_no_valid: got %0d want 0", bad_we - b0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[4+i] !== data[i]) begin
        failures++; $display("FAIL wr_mem%0d: got %h want %h", 4 + i, mem[4+i], data[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_read_burst;
    int lat;
    bit ok, seen;
    logic [DW-1:0] e, o;
    exp_rd.push_back(32'hB); exp_rd.push_back(32'hC);
    bus.rd_ready = 1'b1;
    obs_rd_cyc.delete();
    issue_cmd(1'b1, AW'(5), LW'(2), ok);
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (bus.rd_valid) seen = 1'b1;
    end
    // First negedge after acceptance is RD_ADDR, so rd_valid shows on the third.
    checks++;
    if (!ok || lat != 3) begin
      failures++; $display("FAIL rd_latency: got %0d want 3 (accepted=%0b)", lat, ok);
    end
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rd_done: got timeout want done"); end
    checks++;
    if (obs_rd_cyc.size() != 2 || obs_rd_cyc[1] - obs_rd_cyc[0] != 3) begin
      failures++; $display("FAIL rd_throughput: got %0d beats want 2 beats 3 cycles apart",
                           obs_rd_cyc.size());
    end
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front(); o = '0;
      if (obs_rd.size() > 0) o = obs_rd.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL rd_sb: got %h want %h", o, e); end
    end
    checks++;
    if (obs_wr.size() != 0) begin
      failures++; $display("FAIL rd_no_write: got %0d writes want 0", obs_wr.size());
    end
    obs_wr.delete(); obs_rd.delete(); obs_rd_cyc.delete();
  endtask

  task automatic test_backpressure;
    int bad;
    bit ok, seen;
    logic [DW-1:0] e, o;
    exp_rd.push_back(32'hA); exp_rd.push_back(32'hB);
    bus.rd_ready = 1'b0;
    issue_cmd(1'b1, AW'(4), LW'(2), ok);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.rd_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || bus.rd_data !== 32'hA) begin
      failures++; $display("FAIL bp_first: got valid=%0b data=%h want 1 0000000a", seen, bus.rd_data);
    end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hA || bus.mem_addr !== AW'(4)) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    @(posedge clk); #1;
    bus.rd_ready = 1'b1;
    wait_done(ok);
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front(); o = '0;
      if (obs_rd.size() > 0) o = obs_rd.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL bp_sb: got %h want %h", o, e); end
    end
    checks++;
    if (obs_rd.size() != 0) begin
      failures++; $display("FAIL bp_extra: got %0d extra beats want 0", obs_rd.size());
    end
    obs_rd.delete(); obs_rd_cyc.delete(); obs_wr.delete();
  endtask

  task automatic test_wrap_stall;
    int d0, b0;
    bit ok, all_ok;
    logic [AW+DW-1:0] e, o;
    logic [AW-1:0] addrs [4];
    int gaps [4];
    addrs[0] = AW'(30); addrs[1] = AW'(31); addrs[2] = AW'(0); addrs[3] = AW'(1);
    gaps[0] = 1; gaps[1] = 2; gaps[2] = 0; gaps[3] = 1;
    d0 = done_cnt; b0 = bad_we; all_ok = 1'b1;
    for (int i = 0; i < 4; i++) exp_wr.push_back({addrs[i], DW'(32'h11 + i)});
    issue_cmd(1'b0, AW'(30), LW'(4), ok);
    all_ok &= ok;
    for (int i = 0; i < 4; i++) begin send_beat(DW'(32'h11 + i), gaps[i], ok); all_ok &= ok; end
    wait_done(ok);
    all_ok &= ok;
    checks++;
    if (!all_ok) begin failures++; $display("FAIL wrap_handshakes: got timeout want completion"); end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = '0;
      if (obs_wr.size() > 0) o = obs_wr.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL wrap_sb: got addr=%0d data=%h want addr=%0d data=%h", o[DW+:AW],
                 o[DW-1:0], e[DW+:AW], e[DW-1:0]);
      end
    end
    checks++;
    if (obs_wr.size() != 0 || bad_we != b0 || done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL wrap_side: got extra=%0d stray_we=%0d dones=%0d want 0 0 1", obs_wr.size(),
               bad_we - b0, done_cnt - d0);
    end
    obs_wr.delete();
  endtask

  task automatic test_len_zero;
    bit ok;
    issue_cmd(1'b0, AW'(7), LW'(0), ok);
    @(negedge clk);
    checks++;
    if (!ok || {bus.done, bus.busy, bus.cmd_ready} !== 3'b110) begin
      failures++; $display("FAIL len0_done: got %b want 110", {bus.done, bus.busy, bus.cmd_ready});
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.busy, bus.cmd_ready} !== 3'b001) begin
      failures++; $display("FAIL len0_idle: got %b want 001", {bus.done, bus.busy, bus.cmd_ready});
    end
    checks++;
    if (obs_wr.size() != 0 || obs_rd.size() != 0) begin
      failures++; $display("FAIL len0_access: got wr=%0d rd=%0d want 0 0", obs_wr.size(),
                           obs_rd.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst;
    int d0;
    bit ok;
    logic [AW+DW-1:0] e, o;
    logic [DW-1:0] er, orr;
    d0 = done_cnt;
    exp_wr.push_back({AW'(10), 32'hD1}); exp_wr.push_back({AW'(11), 32'hD2});
    issue_cmd(1'b0, AW'(10), LW'(4), ok);
    send_beat(32'hD1, 0, ok);
    send_beat(32'hD2, 0, ok);
    rst_n = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hD3;
    #1;
    checks++;
    if ({bus.mem_we, bus.busy, bus.wr_ready, bus.cmd_ready, bus.done, bus.rd_valid} !== 6'b100000)
    begin
      failures++;
      $display("FAIL rstmid_ctrl: got %b want 100000", {bus.mem_we, bus.busy, bus.wr_ready,
               bus.cmd_ready, bus.done, bus.rd_valid});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.rd_data} !== '0) begin
      failures++;
      $display("FAIL rstmid_data: got addr=%0d wdata=%h rdata=%h want 0", bus.mem_addr,
               bus.mem_wdata, bus.rd_data);
    end
    repeat (2) @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    rst_n = 1'b1;
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = '0;
      if (obs_wr.size() > 0) o = obs_wr.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rstmid_sb: got addr=%0d data=%h want addr=%0d data=%h", o[DW+:AW],
                 o[DW-1:0], e[DW+:AW], e[DW-1:0]);
      end
    end
    checks++;
    if (obs_wr.size() != 0 || mem[12] !== '0 || done_cnt != d0) begin
      failures++;
      $display("FAIL rstmid_abort: got extra=%0d mem12=%h dones=%0d want 0 0 0", obs_wr.size(),
               mem[12], done_cnt - d0);
    end
    obs_wr.delete();
    exp_rd.push_back(32'hD1); exp_rd.push_back(32'hD2);
    bus.rd_ready = 1'b1;
    issue_cmd(1'b1, AW'(10), LW'(2), ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rstmid_newcmd: got no accept want accept"); end
    wait_done(ok);
    while (exp_rd.size() > 0) begin
      er = exp_rd.pop_front(); orr = '0;
      if (obs_rd.size() > 0) orr = obs_rd.pop_front();
      checks++;
      if (orr !== er) begin failures++; $display("FAIL rstmid_rd_sb: got %h want %h", orr, er); end
    end
    obs_rd.delete(); obs_rd_cyc.delete();
  endtask

  task automatic test_back_to_back;
    int d0;
    bit ok;
    logic [AW+DW-1:0] e, o;
    logic [DW-1:0] er, orr;
    d0 = done_cnt;
    exp_wr.push_back({AW'(20), 32'h55});
    exp_rd.push_back(32'h55);
    issue_cmd(1'b0, AW'(20), LW'(1), ok);
    // Next command is held while the write is still in progress.
    bus.cmd_valid = 1'b1; bus.cmd_read = 1'b1; bus.cmd_addr = AW'(20); bus.cmd_len = LW'(1);
    bus.wr_valid = 1'b1; bus.wr_data = 32'h55;
    @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.busy} !== 2'b01) begin
      failures++; $display("FAIL b2b_busy: got %b want 01", {bus.cmd_ready, bus.busy});
    end
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    issue_cmd(1'b1, AW'(20), LW'(1), ok);
    wait_done(ok);
    checks++;
    if (!ok || done_cnt - d0 != 2) begin
      failures++; $display("FAIL b2b_dones: got %0d want 2", done_cnt - d0);
    end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = '0;
      if (obs_wr.size() > 0) o = obs_wr.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b_wr_sb: got addr=%0d data=%h want addr=%0d data=%h", o[DW+:AW],
                 o[DW-1:0], e[DW+:AW], e[DW-1:0]);
      end
    end
    while (exp_rd.size() > 0) begin
      er = exp_rd.pop_front(); orr = '0;
      if (obs_rd.size() > 0) orr = obs_rd.pop_front();
      checks++;
      if (orr !== er) begin failures++; $display("FAIL b2b_rd_sb: got %h want %h", orr, er); end
    end
    obs_wr.delete(); obs_rd.delete(); obs_rd_cyc.delete();
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_read = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_backpressure();
    test_wrap_stall();
    test_len_zero();
    test_reset_mid_burst();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
